// File: rtl/trap_pkg.sv
// trap_pkg: CSR map, cause codes, csr_op encodings and FSM/event enums shared by the trap controller
package trap_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE = 12'h304;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL = 12'h343;
  localparam logic [11:0] CSR_MIP = 12'h344;
  localparam logic [1:0] CSR_OP_NOP = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;
  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_LOAD_FAULT = 5'd5;
  localparam logic [4:0] CAUSE_STORE_FAULT = 5'd7;
  localparam logic [4:0] CAUSE_ECALL = 5'd11;
  localparam int IRQ_BASE = 16;
  localparam int MSTATUS_MIE_BIT = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_COMMIT, ST_REDIRECT} state_t;
  typedef enum logic [1:0] {KIND_EXC, KIND_IRQ, KIND_MRET} kind_t;
endpackage

// File: rtl/trap_csr_file.sv
// trap_csr_file: machine trap CSR storage, combinational read mux, software writes and trap/mret commits
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_we,
  input  logic [1:0]         sw_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    sw_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [NUM_IRQ-1:0] irq_sync,
  input  logic               trap_commit,
  input  logic               mret_commit,
  input  logic [XLEN-1:0]    trap_mepc,
  input  logic [XLEN-1:0]    trap_mcause,
  input  logic [XLEN-1:0]    trap_mtval,
  output logic               mstatus_mie,
  output logic [NUM_IRQ-1:0] irq_enabled,
  output logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    mepc
);
  logic st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mstatus, mip, wr;
  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtval;

  function automatic logic [XLEN-1:0] csr_apply(input logic [1:0] op, input logic [XLEN-1:0] old, input logic [XLEN-1:0] wd);
    return op == CSR_OP_WRITE ? wd : op == CSR_OP_SET ? old | wd : op == CSR_OP_CLEAR ? old & ~wd : old;
  endfunction

  always_comb begin
    mstatus = '0;
    mstatus[12:11] = 2'b11;
    mstatus[MSTATUS_MPIE_BIT] = st_mpie_q;
    mstatus[MSTATUS_MIE_BIT] = st_mie_q;
    mip = '0;
    mip[IRQ_BASE +: NUM_IRQ] = irq_sync;
    csr_rdata = csr_addr == CSR_MSTATUS ? mstatus :
                csr_addr == CSR_MIE ? mie_q :
                csr_addr == CSR_MTVEC ? mtvec_q :
                csr_addr == CSR_MEPC ? mepc_q :
                csr_addr == CSR_MCAUSE ? mcause_q :
                csr_addr == CSR_MTVAL ? mtval_q :
                csr_addr == CSR_MIP ? mip : '0;
    wr = csr_apply(sw_op, csr_rdata, sw_wdata);
    wr_mstatus = sw_we && csr_addr == CSR_MSTATUS;
    wr_mie = sw_we && csr_addr == CSR_MIE;
    wr_mtvec = sw_we && csr_addr == CSR_MTVEC;
    wr_mepc = sw_we && csr_addr == CSR_MEPC;
    wr_mcause = sw_we && csr_addr == CSR_MCAUSE;
    wr_mtval = sw_we && csr_addr == CSR_MTVAL;
    st_mie_d = trap_commit ? 1'b0 : mret_commit ? st_mpie_q : wr_mstatus ? wr[MSTATUS_MIE_BIT] : st_mie_q;
    st_mpie_d = trap_commit ? st_mie_q : mret_commit ? 1'b1 : wr_mstatus ? wr[MSTATUS_MPIE_BIT] : st_mpie_q;
    mie_d = wr_mie ? wr : mie_q;
    mtvec_d = wr_mtvec ? wr : mtvec_q;
    mepc_d = trap_commit ? trap_mepc & ~XLEN'(3) : wr_mepc ? wr & ~XLEN'(3) : mepc_q;
    mcause_d = trap_commit ? trap_mcause : wr_mcause ? wr : mcause_q;
    mtval_d = trap_commit ? trap_mtval : wr_mtval ? wr : mtval_q;
    mstatus_mie = st_mie_q;
    irq_enabled = irq_sync & mie_q[IRQ_BASE +: NUM_IRQ];
    mtvec = mtvec_q;
    mepc = mepc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie_q <= 1'b0;
      st_mpie_q <= 1'b0;
      mie_q <= '0;
      mtvec_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
    end else begin
      st_mie_q <= st_mie_d;
      st_mpie_q <= st_mpie_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
    end
  end
endmodule

// File: rtl/trap_controller.sv
// trap_controller: irq synchroniser, event arbitration and IDLE/FLUSH/COMMIT/REDIRECT trap sequencer
module trap_controller
  import trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_illegal,
  input  logic               exc_ecall,
  input  logic               exc_load_fault,
  input  logic               exc_store_fault,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  output logic               flush,
  output logic               busy,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc
);
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  state_t state_q, state_d;
  kind_t kind_q, kind_d;
  logic [XLEN-1:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
  logic [XLEN-1:0] mtvec, mepc, base, target;
  logic [NUM_IRQ-1:0] irq_enabled;
  logic [4:0] irq_code;
  logic mstatus_mie, idle, any_exc, irq_pend, accept, sw_we, trap_commit, mret_commit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq};
    irq_code = 5'(IRQ_BASE);
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_enabled[i]) irq_code = 5'(IRQ_BASE + i);
    idle = state_q == ST_IDLE;
    any_exc = exc_illegal | exc_ecall | exc_load_fault | exc_store_fault;
    irq_pend = mstatus_mie & |irq_enabled;
    accept = idle & (any_exc | mret | irq_pend);
    sw_we = csr_we & idle & ~accept;
    kind_d = !accept ? kind_q : any_exc ? KIND_EXC : mret ? KIND_MRET : KIND_IRQ;
    cause_d = !accept ? cause_q :
              exc_illegal ? XLEN'(CAUSE_ILLEGAL) :
              exc_ecall ? XLEN'(CAUSE_ECALL) :
              exc_load_fault ? XLEN'(CAUSE_LOAD_FAULT) :
              exc_store_fault ? XLEN'(CAUSE_STORE_FAULT) :
              mret ? cause_q : {1'b1, (XLEN-1)'(irq_code)};
    epc_d = !accept ? epc_q : (any_exc ? epc_cur : epc_next) & ~XLEN'(3);
    tval_d = !accept ? tval_q :
             exc_illegal ? epc_cur :
             exc_ecall ? XLEN'(0) :
             (exc_load_fault | exc_store_fault) ? exc_tval : XLEN'(0);
    state_d = idle ? (accept ? ST_FLUSH : ST_IDLE) :
              state_q == ST_FLUSH ? ST_COMMIT :
              state_q == ST_COMMIT ? ST_REDIRECT : ST_IDLE;
    trap_commit = state_q == ST_COMMIT && kind_q != KIND_MRET;
    mret_commit = state_q == ST_COMMIT && kind_q == KIND_MRET;
    base = {mtvec[XLEN-1:2], 2'b00};
    target = kind_q == KIND_MRET ? mepc :
             kind_q == KIND_IRQ && mtvec[1:0] == 2'b01 ? base + {cause_q[XLEN-3:0], 2'b00} : base;
    flush = state_q == ST_FLUSH;
    busy = !idle;
    redirect = state_q == ST_REDIRECT;
    redirect_pc = redirect ? target : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      state_q <= ST_IDLE;
      kind_q <= KIND_EXC;
      cause_q <= '0;
      epc_q <= '0;
      tval_q <= '0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      kind_q <= kind_d;
      cause_q <= cause_d;
      epc_q <= epc_d;
      tval_q <= tval_d;
    end
  end

  trap_csr_file #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) u_csr (
    .clk         (clk),
    .rst         (rst),
    .sw_we       (sw_we),
    .sw_op       (csr_op),
    .csr_addr    (csr_addr),
    .sw_wdata    (csr_wdata),
    .csr_rdata   (csr_rdata),
    .irq_sync    (sync_q[SYNC_STAGES-1]),
    .trap_commit (trap_commit),
    .mret_commit (mret_commit),
    .trap_mepc   (epc_q),
    .trap_mcause (cause_q),
    .trap_mtval  (tval_q),
    .mstatus_mie (mstatus_mie),
    .irq_enabled (irq_enabled),
    .mtvec       (mtvec),
    .mepc        (mepc)
  );
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: randomized scoreboard bench for trap_controller against a CSR-level reference model
module tb_trap_controller;
  import trap_pkg::*;
  localparam int XLEN = 32;
  localparam int NUM_IRQ = 4;
  localparam int SYNC_STAGES = 2;
  localparam logic [4:0] EV_ILL = 5'b10000;
  localparam logic [4:0] EV_ECALL = 5'b01000;
  localparam logic [4:0] EV_LD = 5'b00100;
  localparam logic [4:0] EV_MRET = 5'b00001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic csr_we, exc_illegal, exc_ecall, exc_load_fault, exc_store_fault, mret;
  logic [1:0] csr_op;
  logic [11:0] csr_addr = 12'h0;
  logic [XLEN-1:0] csr_wdata, csr_rdata, redirect_pc;
  logic [XLEN-1:0] exc_tval = '0;
  logic [XLEN-1:0] epc_cur = '0;
  logic [XLEN-1:0] epc_next = '0;
  logic [NUM_IRQ-1:0] irq = '0;
  logic flush, busy, redirect;
  logic rd_chk = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int flush_cyc = -100;
  logic [XLEN-1:0] exp_pc_q[$];
  logic [XLEN-1:0] exp_rd_q[$];
  logic [11:0] csr_list[8] = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, 12'h7C0};
  logic m_mie, m_mpie;
  logic [XLEN-1:0] m_mie_r, m_mtvec, m_mepc, m_mcause, m_mtval;

  trap_controller #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk             (clk),
    .rst             (rst),
    .csr_we          (csr_we),
    .csr_op          (csr_op),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .irq             (irq),
    .exc_illegal     (exc_illegal),
    .exc_ecall       (exc_ecall),
    .exc_load_fault  (exc_load_fault),
    .exc_store_fault (exc_store_fault),
    .exc_tval        (exc_tval),
    .mret            (mret),
    .epc_cur         (epc_cur),
    .epc_next        (epc_next),
    .flush           (flush),
    .busy            (busy),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic string csr_name(input logic [11:0] a);
    case (a)
      CSR_MSTATUS: return "mstatus";
      CSR_MIE: return "mie";
      CSR_MTVEC: return "mtvec";
      CSR_MEPC: return "mepc";
      CSR_MCAUSE: return "mcause";
      CSR_MTVAL: return "mtval";
      CSR_MIP: return "mip";
      default: return "unmapped";
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (flush) flush_cyc = cyc;
    if (redirect) begin
      if (exp_pc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL redirect_unexpected: got %h expected no redirect", redirect_pc);
      end else chk("redirect_pc", redirect_pc, exp_pc_q.pop_front());
      chk("flush_to_redirect_cycles", XLEN'(cyc - flush_cyc), XLEN'(2));
    end
    if (rd_chk) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got %h expected no read", csr_rdata);
      end else chk(csr_name(csr_addr), csr_rdata, exp_rd_q.pop_front());
    end
  end

  function automatic logic [XLEN-1:0] m_read(input logic [11:0] a);
    case (a)
      CSR_MSTATUS: return 32'h1800 | (XLEN'(m_mpie) << 7) | (XLEN'(m_mie) << 3);
      CSR_MIE: return m_mie_r;
      CSR_MTVEC: return m_mtvec;
      CSR_MEPC: return m_mepc;
      CSR_MCAUSE: return m_mcause;
      CSR_MTVAL: return m_mtval;
      CSR_MIP: return XLEN'(irq) << 16;
      default: return '0;
    endcase
  endfunction

  function automatic void m_reset();
    m_mie = 0;
    m_mpie = 0;
    m_mie_r = '0;
    m_mtvec = '0;
    m_mepc = '0;
    m_mcause = '0;
    m_mtval = '0;
  endfunction

  function automatic void m_write(input logic [1:0] op, input logic [11:0] a, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] old, nv;
    old = m_read(a);
    nv = op == 2'b01 ? wd : op == 2'b10 ? (old | wd) : op == 2'b11 ? (old & ~wd) : old;
    case (a)
      CSR_MSTATUS: begin m_mie = nv[3]; m_mpie = nv[7]; end
      CSR_MIE: m_mie_r = nv;
      CSR_MTVEC: m_mtvec = nv;
      CSR_MEPC: m_mepc = nv & ~32'h3;
      CSR_MCAUSE: m_mcause = nv;
      CSR_MTVAL: m_mtval = nv;
      default: ;
    endcase
  endfunction

  function automatic void m_trap(input logic [XLEN-1:0] cause, input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval, input bit is_irq);
    logic [XLEN-1:0] base;
    base = m_mtvec & ~32'h3;
    m_mepc = epc & ~32'h3;
    m_mcause = cause;
    m_mtval = tval;
    m_mpie = m_mie;
    m_mie = 0;
    exp_pc_q.push_back(is_irq && m_mtvec[1:0] == 2'b01 ? base + 4 * (cause & 32'h7FFF_FFFF) : base);
  endfunction

  function automatic void m_mret();
    exp_pc_q.push_back(m_mepc);
    m_mie = m_mpie;
    m_mpie = 1;
  endfunction

  function automatic bit m_pending();
    return m_mie && ((irq & m_mie_r[16 +: NUM_IRQ]) != 0);
  endfunction

  function automatic void m_irq_entry();
    int idx;
    idx = 0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq[i] && m_mie_r[16 + i]) idx = i;
    m_trap(32'h8000_0000 | XLEN'(16 + idx), epc_next, '0, 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csr_we = 0;
    csr_op = 2'b00;
    csr_wdata = '0;
    {exc_illegal, exc_ecall, exc_load_fault, exc_store_fault, mret} = 5'b0;
    rd_chk = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy=1 expected busy=0 within 10 cycles");
    end
  endtask

  task automatic settle();
    wait_idle();
    if (m_pending()) begin
      m_irq_entry();
      tick();
      wait_idle();
    end
  endtask

  task automatic step(input logic [4:0] ev, input logic we, input logic [1:0] op, input logic [11:0] a, input logic [XLEN-1:0] wd);
    {exc_illegal, exc_ecall, exc_load_fault, exc_store_fault, mret} = ev;
    csr_we = we;
    csr_op = op;
    csr_addr = a;
    csr_wdata = wd;
    if (ev[4]) m_trap(32'd2, epc_cur, epc_cur, 0);
    else if (ev[3]) m_trap(32'd11, epc_cur, '0, 0);
    else if (ev[2]) m_trap(32'd5, epc_cur, exc_tval, 0);
    else if (ev[1]) m_trap(32'd7, epc_cur, exc_tval, 0);
    else if (ev[0]) m_mret();
    else if (we) m_write(op, a, wd);
    tick();
    idle_inputs();
    settle();
  endtask

  task automatic set_irq(input logic [NUM_IRQ-1:0] v);
    irq = v;
    repeat (SYNC_STAGES) tick();
  endtask

  task automatic check_all();
    foreach (csr_list[k]) begin
      csr_addr = csr_list[k];
      rd_chk = 1;
      exp_rd_q.push_back(m_read(csr_list[k]));
      tick();
    end
    rd_chk = 0;
  endtask

  initial begin
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", XLEN'(flush), 0);
    chk("rst_busy", XLEN'(busy), 0);
    chk("rst_redirect", XLEN'(redirect), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst = 0;
    tick();
    check_all();
    step(5'b0, 1, CSR_OP_WRITE, CSR_MTVEC, 32'h100);
    epc_cur = 32'h40;
    exc_illegal = 1;
    m_trap(32'd2, epc_cur, epc_cur, 0);
    tick();
    idle_inputs();
    chk("t1_flush", XLEN'(flush), 1);
    chk("t1_busy", XLEN'(busy), 1);
    tick();
    chk("t2_flush", XLEN'(flush), 0);
    chk("t2_busy", XLEN'(busy), 1);
    tick();
    csr_addr = CSR_MEPC;
    #1;
    chk("t3_redirect", XLEN'(redirect), 1);
    chk("t3_mepc", csr_rdata, 32'h40);
    settle();
    check_all();
    step(5'b0, 1, CSR_OP_WRITE, CSR_MTVEC, 32'h201);
    step(5'b0, 1, CSR_OP_WRITE, CSR_MIE, 32'h0002_0000);
    epc_next = 32'h84;
    set_irq(4'b0010);
    settle();
    step(5'b0, 1, CSR_OP_SET, CSR_MSTATUS, 32'h8);
    check_all();
    set_irq(4'b0000);
    settle();
    step(EV_MRET, 0, 2'b00, 12'h0, '0);
    set_irq(4'b0010);
    exc_tval = 32'h1234;
    epc_cur = 32'h50;
    step(EV_LD, 0, 2'b00, 12'h0, '0);
    check_all();
    step(EV_MRET, 0, 2'b00, 12'h0, '0);
    check_all();
    set_irq(4'b0000);
    settle();
    step(5'b0, 1, CSR_OP_WRITE, CSR_MEPC, 32'h88);
    step(EV_MRET, 0, 2'b00, 12'h0, '0);
    check_all();
    epc_cur = 32'h60;
    step(EV_ECALL, 1, CSR_OP_WRITE, CSR_MTVEC, 32'hABC);
    check_all();
    exc_illegal = 1;
    m_trap(32'd2, epc_cur, epc_cur, 0);
    tick();
    idle_inputs();
    tick();
    chk("commit_busy", XLEN'(busy), 1);
    rst = 1;
    #1;
    chk("midrst_busy", XLEN'(busy), 0);
    chk("midrst_redirect_pc", redirect_pc, 0);
    exp_pc_q.delete();
    m_reset();
    tick();
    rst = 0;
    tick();
    check_all();
    for (int it = 0; it < 300; it++) begin
      epc_cur = $urandom;
      epc_next = $urandom;
      exc_tval = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2: step(5'b0, 1, 2'($urandom), csr_list[$urandom_range(0, 7)], $urandom);
        3: step({4'($urandom_range(1, 15)), 1'($urandom)}, 1'($urandom), 2'($urandom), csr_list[$urandom_range(0, 7)], $urandom);
        4: step(EV_MRET, 1'($urandom), 2'($urandom), csr_list[$urandom_range(0, 7)], $urandom);
        5: begin
          set_irq(NUM_IRQ'($urandom));
          settle();
        end
        default: check_all();
      endcase
    end
    check_all();
    chk("redirect_queue_drained", XLEN'(exp_pc_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion expected finish before 600000 time units");
    $fatal(1);
  end
endmodule
